write_through_buffer: RTL
=========================

Name: write_through_buffer

Overview:
- Posted-write FIFO between the write-through cache controller and main memory.
- Absorbs write-through stores so cache write hits and misses need not stall for the full memory write time.
- Drains entries to main memory in order whenever the memory port is free.
- Flags read-miss hazards against pending entries so a block refill never reads stale memory.

Parameters:
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 32, data word width.
- DEPTH, 4, number of buffered entries (power of two, at least 2).
- OFFSET_BITS, 2, word-in-block offset bits (4 words per block).
- MEM_WR_CYCLES, 1, cycles mem_write is held per memory write (at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_req  in  1  cache controller posts a write this cycle.
- wr_addr  in  ADDR_WIDTH  word address of the posted write.
- wr_data  in  DATA_WIDTH  data of the posted write.
- wr_ready  out  1  posted write will be accepted at the next edge.
- rd_addr  in  ADDR_WIDTH  word address of the pending read miss.
- rd_check  in  1  rd_addr is valid for the hazard check.
- rd_hazard  out  1  a buffered entry hits the same block as rd_addr.
- mem_busy  in  1  memory port is owned by a refill; no drain may start.
- mem_write  out  1  write strobe to main memory.
- mem_addr  out  ADDR_WIDTH  main memory write address.
- mem_data  out  DATA_WIDTH  main memory write data.
- empty  out  1  no valid entries.
- drained  out  1  empty and the drain FSM is in IDLE.

Behaviour:
- Reset (async, active-low): all entries invalid, pointers and count 0, FSM IDLE, drain counter 0. Outputs: mem_write 0, mem_addr 0, mem_data 0, empty 1, drained 1, rd_hazard 0, wr_ready 1. On reset assertion mid-write, mem_write drops immediately and the entry is lost (memory contents undefined for it).
- Push: accepted at an edge when wr_req && wr_ready. The entry is stored at the tail and count increments.
- Merge: if wr_req, count>0, wr_addr equals the newest entry's address, and the newest entry is not the head currently in WRITE, then overwrite that entry's data only. Count is unchanged.
- wr_ready = (count<DEPTH) || merge_hit. This is combinational from registered state and wr_addr.
- Push with wr_ready=0 is ignored. The controller must hold wr_req and stall.
- Drain FSM, states IDLE and WRITE:
  - IDLE -> WRITE when count>0 && !mem_busy, sampled at the edge. The drain counter loads MEM_WR_CYCLES-1.
  - In WRITE: mem_write=1; mem_addr/mem_data come combinationally from the head entry. mem_busy is ignored once WRITE is entered.
  - WRITE: counter decrements each edge. On the edge where the counter==0, pop the head and return to IDLE. This forces a 1-cycle IDLE gap between writes.
  - In IDLE, mem_write=0. mem_addr/mem_data hold their last values (0 after reset).
- Latency with MEM_WR_CYCLES=1: push at edge N, mem_write high during cycle N+1..N+2 (one cycle), pop at edge N+2.
- Simultaneous push and pop: both take effect and count is unchanged. A push when full while a pop happens is still refused, because wr_ready does not look ahead.
- Pointers wrap modulo DEPTH. Count has width log2(DEPTH)+1.
- Hazard: rd_hazard = rd_check && any valid entry whose address[ADDR_WIDTH-1:OFFSET_BITS] equals rd_addr[ADDR_WIDTH-1:OFFSET_BITS]. It includes the head in WRITE until its pop edge. This output is combinational. The controller delays refill until rd_hazard=0.
- empty = (count==0). drained = empty && FSM==IDLE.

Decomposition:
- Shared package cache_pkg: ADDR_WIDTH, DATA_WIDTH, OFFSET_BITS, WORDS_PER_BLOCK, BLOCK_ADDR_WIDTH, drain FSM state encoding (IDLE=0, WRITE=1).
- Sub-module wb_entry_fifo holds the storage, pointers, count, merge write port and per-entry block-compare vector.
- The top level holds the drain FSM, drain counter and hazard reduction.

Test Plan:
- Reset release, then push addr 0x003 data 0x35 with mem_busy=0 -> mem_write=1, mem_addr=0x003, mem_data=0x35 for exactly one cycle starting one edge after the push; empty=1 and drained=1 one edge later.
- Four pushes 0x000/0x5, 0x001/0x15, 0x002/0x25, 0x3FF/0x5C79 with mem_busy=1 -> wr_ready=0 after the 4th; a 5th push 0x010/0x99 is ignored. Drop mem_busy -> four writes in FIFO order, one IDLE cycle apart.
- With mem_busy=1, push 0x008/0x11 then 0x008/0x22 -> count stays 1; after release the single memory write is 0x008/0x22.
- With 0x009/0x22 buffered, rd_check=1, rd_addr=0x00B -> rd_hazard=1. rd_addr=0x020 -> rd_hazard=0. rd_hazard clears on the pop edge of 0x009.
- MEM_WR_CYCLES=3: push 0x060/0x0 -> mem_write held 3 cycles; toggling mem_busy during WRITE has no effect.
- Assert reset mid-WRITE -> mem_write=0 immediately, empty=1; no further memory writes after release.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side constants and drain FSM state encoding for the
// write-through buffer.
package cache_pkg;

    localparam int ADDR_WIDTH       = 10;
    localparam int DATA_WIDTH       = 32;
    localparam int OFFSET_BITS      = 2;
    localparam int WORDS_PER_BLOCK  = 1 << OFFSET_BITS;
    localparam int BLOCK_ADDR_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef logic [0:0] drain_state_t;

    localparam drain_state_t ST_IDLE  = 1'b0;
    localparam drain_state_t ST_WRITE = 1'b1;

endpackage

// File: rtl/wb_entry_fifo.sv
// Storage for posted writes: circular buffer with count, in-place data merge
// into the newest entry, and a per-entry block-address compare vector.
module wb_entry_fifo #(
    parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
    parameter int DEPTH       = 4,
    parameter int OFFSET_BITS = cache_pkg::OFFSET_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          merge,
    input  logic                          pop,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] rd_block,
    output logic [ADDR_WIDTH-1:0]         head_addr,
    output logic [DATA_WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          newest_match,
    output logic [DEPTH-1:0]              block_match
);
    import cache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      newest;

    assign newest    = tail - PTR_W'(1);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    assign newest_match = (count != '0) && (addr_mem[newest] == wr_addr);

    always_comb begin
        block_match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            block_match[i] = valid[i] &&
                (addr_mem[i][ADDR_WIDTH-1:OFFSET_BITS] == rd_block);
        end
    end

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= wr_addr;
            data_mem[tail] <= wr_data;
        end
        if (merge) begin
            data_mem[newest] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/write_through_buffer.sv
// Posted-write buffer between the write-through cache controller and memory:
// drain FSM, drain counter, merge/accept decision and read-miss hazard.
module write_through_buffer #(
    parameter int ADDR_WIDTH    = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH    = cache_pkg::DATA_WIDTH,
    parameter int DEPTH         = 4,
    parameter int OFFSET_BITS   = cache_pkg::OFFSET_BITS,
    parameter int MEM_WR_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_check,
    output logic                  rd_hazard,
    input  logic                  mem_busy,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  empty,
    output logic                  drained
);
    import cache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int DC_W  = (MEM_WR_CYCLES > 1) ? $clog2(MEM_WR_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(MEM_WR_CYCLES - 1);

    drain_state_t          state;
    logic [DC_W-1:0]       drain_cnt;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0] last_data;

    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CW-1:0]         count;
    logic                  newest_match;
    logic [DEPTH-1:0]      block_match;

    logic in_write;
    logic merge_hit;
    logic push;
    logic merge;
    logic pop;
    logic unused_rd_offset;

    assign unused_rd_offset = ^rd_addr[OFFSET_BITS-1:0];

    assign in_write = (state == ST_WRITE);

    // The head being written to memory is frozen; a same-address store
    // behind it becomes a new entry instead of a merge.
    assign merge_hit = newest_match && !(in_write && (count == CW'(1)));
    assign wr_ready  = (count < CW'(DEPTH)) || merge_hit;
    assign merge     = wr_req && merge_hit;
    assign push      = wr_req && wr_ready && !merge_hit;
    assign pop       = in_write && (drain_cnt == '0);

    wb_entry_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .merge        (merge),
        .pop          (pop),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_block     (rd_addr[ADDR_WIDTH-1:OFFSET_BITS]),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .count        (count),
        .newest_match (newest_match),
        .block_match  (block_match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((count != '0) && !mem_busy) begin
                        state     <= ST_WRITE;
                        drain_cnt <= DC_LOAD;
                    end
                end
                default: begin
                    if (drain_cnt == '0) begin
                        state     <= ST_IDLE;
                        last_addr <= head_addr;
                        last_data <= head_data;
                    end else begin
                        drain_cnt <= drain_cnt - DC_W'(1);
                    end
                end
            endcase
        end
    end

    assign mem_write = in_write;
    assign mem_addr  = in_write ? head_addr : last_addr;
    assign mem_data  = in_write ? head_data : last_data;

    assign empty     = (count == '0);
    assign drained   = empty && !in_write;
    assign rd_hazard = rd_check && (|block_match);

endmodule
